// File: rtl/dac081c081_sequencer_if.sv
// Transaction handshake between the DAC sequencer and the single-transaction
// I2C master core: one go pulse starts a write of two bytes to one address,
// one done pulse (with nack status) ends it.
interface dac081c081_sequencer_if;
  logic        i2c_go_o;
  logic [6:0]  i2c_adr_o;
  logic [15:0] i2c_dat_o;
  logic        i2c_busy_i;
  logic        i2c_done_i;
  logic        i2c_nack_i;

  // Sequencer side: issues transactions, observes completion.
  modport master (
    output i2c_go_o, i2c_adr_o, i2c_dat_o,
    input  i2c_busy_i, i2c_done_i, i2c_nack_i
  );

  // I2C core side: accepts transactions, reports completion.
  modport slave (
    input  i2c_go_o, i2c_adr_o, i2c_dat_o,
    output i2c_busy_i, i2c_done_i, i2c_nack_i
  );
endinterface

// File: rtl/dac081c081_sequencer.sv
// Shadow-register sequencer for up to four DAC081C081 devices sharing one
// I2C bus. Writes mark a channel dirty; dirty channels are pushed out one at
// a time in round-robin order, NACKed transfers are retried a bounded number
// of times, and channels that keep failing raise a sticky error flag.
module dac081c081_sequencer #(
  parameter int                   NUM_DAC   = 3,
  parameter logic [7*NUM_DAC-1:0] ADDR_LIST = {7'h0E, 7'h0D, 7'h0C},
  parameter int                   MAX_RETRY = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr_i,
  input  logic [1:0]               wr_ch_i,
  input  logic [7:0]               wr_data_i,
  input  logic [1:0]               wr_pd_i,
  input  logic                     refresh_i,
  input  logic                     err_clr_i,
  dac081c081_sequencer_if.master   i2c,
  output logic                     busy_o,
  output logic [NUM_DAC-1:0]       err_o,
  output logic [10*NUM_DAC-1:0]    shadow_o
);

  localparam logic [2:0] NUM_DAC_W   = 3'(NUM_DAC);
  localparam logic [2:0] MAX_RETRY_W = 3'(MAX_RETRY);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t           state;
  logic [9:0]       shadow   [NUM_DAC];
  logic [6:0]       addr_tbl [NUM_DAC];
  logic [NUM_DAC-1:0] dirty;
  logic [1:0]       rr_ptr;
  logic [1:0]       cur_ch;
  logic [1:0]       next_ch;
  logic [2:0]       retry_cnt;
  logic             wr_ok;
  logic             sel_valid;
  logic [1:0]       sel_ch;

  // Writes to channels that do not exist are dropped.
  assign wr_ok = wr_i && ({1'b0, wr_ch_i} < NUM_DAC_W);

  // Channel following the one in flight, wrapping at NUM_DAC.
  assign next_ch = ({1'b0, cur_ch} == NUM_DAC_W - 3'd1) ? 2'd0 : cur_ch + 2'd1;

  assign busy_o = (state != IDLE) || (|dirty);

  for (genvar k = 0; k < NUM_DAC; k++) begin : g_ch
    assign addr_tbl[k]          = ADDR_LIST[7*k +: 7];
    assign shadow_o[10*k +: 10] = shadow[k];
  end

  // Round-robin pick: first dirty channel at or after rr_ptr. Scanning from
  // the far end lets the nearest candidate overwrite the others.
  always_comb begin
    logic [2:0] idx;
    // NOTE: combinational logic uses blocking '=' and assigns every output a
    // default up front, so no path leaves a value held (no inferred latch).
    idx       = '0;
    sel_valid = 1'b0;
    sel_ch    = '0;
    for (int i = NUM_DAC - 1; i >= 0; i--) begin
      idx = {1'b0, rr_ptr} + 3'(i);
      if (idx >= NUM_DAC_W) idx = idx - NUM_DAC_W;
      if (dirty[idx[1:0]]) begin
        sel_valid = 1'b1;
        sel_ch    = idx[1:0];
      end
    end
  end

  // Shadow registers: latest {pd, data} written to each channel.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      // NOTE: this small register array is cleared on reset because its
      // contents are visible on shadow_o; large RAMs would normally be left
      // unreset.
      for (int k = 0; k < NUM_DAC; k++) shadow[k] <= '0;
    end else if (wr_ok) begin
      shadow[wr_ch_i] <= {wr_pd_i, wr_data_i};
    end
  end

  // Transaction scheduler with dirty tracking, retry and sticky error flags.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= IDLE;
      dirty         <= '0;
      err_o         <= '0;
      rr_ptr        <= '0;
      cur_ch        <= '0;
      retry_cnt     <= '0;
      i2c.i2c_go_o  <= 1'b0;
      i2c.i2c_adr_o <= '0;
      i2c.i2c_dat_o <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking '<='; later assignments in
      // this block deliberately override earlier ones (priority by order).
      i2c.i2c_go_o <= 1'b0;
      case (state)
        IDLE: begin
          if (sel_valid) begin
            cur_ch        <= sel_ch;
            i2c.i2c_adr_o <= addr_tbl[sel_ch];
            i2c.i2c_dat_o <= {2'b00, shadow[sel_ch], 4'b0000};
            dirty[sel_ch] <= 1'b0;
            retry_cnt     <= '0;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          if (!i2c.i2c_busy_i) begin
            i2c.i2c_go_o <= 1'b1;
            state        <= WAIT;
          end
        end
        WAIT: begin
          if (i2c.i2c_done_i) begin
            if (!i2c.i2c_nack_i) begin
              rr_ptr <= next_ch;
              state  <= IDLE;
            end else if (retry_cnt < MAX_RETRY_W) begin
              retry_cnt <= retry_cnt + 3'd1;
              state     <= ISSUE;
            end else begin
              err_o[cur_ch] <= 1'b1;
              rr_ptr        <= next_ch;
              state         <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase

      // New writes and refresh win over the selection clear, so a value
      // written while its channel is being latched or in flight is resent.
      if (refresh_i) dirty <= '1;
      if (wr_ok)     dirty[wr_ch_i] <= 1'b1;

      // Clearing errors beats a same-cycle error set.
      if (err_clr_i) err_o <= '0;
    end
  end

endmodule

// File: tb/tb_dac081c081_sequencer.sv
// Self-checking bench for dac081c081_sequencer: directed scenarios plus a
// randomized phase compared against a transaction-level reference model.
module tb_dac081c081_sequencer;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        wr_i;
  logic [1:0]  wr_ch_i;
  logic [7:0]  wr_data_i;
  logic [1:0]  wr_pd_i;
  logic        refresh_i;
  logic        err_clr_i;
  logic        busy_o;
  logic [2:0]  err_o;
  logic [29:0] shadow_o;

  logic        m_busy, m_done, m_nack, force_busy;
  int          nack_mode;   // 0 always ack, 1 always nack, 2 random
  int          fixed_lat;   // 0 means random latency
  logic        chk_hold;

  int checks = 0;
  int errors = 0;

  logic [6:0]  adr_q  [$];
  logic [15:0] dat_q  [$];
  logic        nack_q [$];

  logic [6:0]  exp_addr [3] = '{7'h0C, 7'h0D, 7'h0E};

  dac081c081_sequencer_if bus ();

  assign bus.i2c_busy_i = m_busy | force_busy;
  assign bus.i2c_done_i = m_done;
  assign bus.i2c_nack_i = m_nack;

  dac081c081_sequencer dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .wr_i      (wr_i),
    .wr_ch_i   (wr_ch_i),
    .wr_data_i (wr_data_i),
    .wr_pd_i   (wr_pd_i),
    .refresh_i (refresh_i),
    .err_clr_i (err_clr_i),
    .i2c       (bus),
    .busy_o    (busy_o),
    .err_o     (err_o),
    .shadow_o  (shadow_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] word_of(input logic [1:0] pd, input logic [7:0] d);
    return {2'b00, pd, d, 4'b0000};
  endfunction

  // Transaction monitor: records every cycle in which go is high.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.i2c_go_o === 1'b1) begin
        adr_q.push_back(bus.i2c_adr_o);
        dat_q.push_back(bus.i2c_dat_o);
      end
    end
  end

  // I2C master model: busy after go, done (with nack) after a latency.
  initial begin
    logic [6:0]  a;
    logic [15:0] d;
    int          lat;
    logic        nk;
    m_busy = 1'b0;
    m_done = 1'b0;
    m_nack = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.i2c_go_o === 1'b1) begin
        a      = bus.i2c_adr_o;
        d      = bus.i2c_dat_o;
        m_busy = 1'b1;
        lat    = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 4));
        repeat (lat) @(negedge clk);
        if (nack_mode == 1)      nk = 1'b1;
        else if (nack_mode == 2) nk = ($urandom_range(0, 2) == 0);
        else                     nk = 1'b0;
        if (chk_hold) begin
          check("hold_adr", 32'(bus.i2c_adr_o), 32'(a));
          check("hold_dat", 32'(bus.i2c_dat_o), 32'(d));
        end
        m_done = 1'b1;
        m_nack = nk;
        nack_q.push_back(nk);
        @(negedge clk);
        m_done = 1'b0;
        m_nack = 1'b0;
        m_busy = 1'b0;
      end
    end
  end

  task automatic do_reset();
    int cyc = 0;
    while (m_busy && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    rst_i = 1'b1;
    repeat (2) @(negedge clk);
    adr_q.delete();
    dat_q.delete();
    nack_q.delete();
    rst_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic write(input logic [1:0] ch, input logic [1:0] pd, input logic [7:0] d);
    @(negedge clk);
    wr_i      = 1'b1;
    wr_ch_i   = ch;
    wr_pd_i   = pd;
    wr_data_i = d;
    @(negedge clk);
    wr_i = 1'b0;
  endtask

  task automatic pulse_refresh();
    @(negedge clk);
    refresh_i = 1'b1;
    @(negedge clk);
    refresh_i = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int cyc    = 0;
    int stable = 0;
    while (stable < 4 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (!busy_o && !m_busy) stable++;
      else stable = 0;
    end
    check({tag, "_idle_reached"}, 32'(stable >= 4), 32'd1);
  endtask

  task automatic wait_gos(input int n, input string tag);
    int cyc = 0;
    while (adr_q.size() < n && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_go_seen"}, 32'(adr_q.size() >= n), 32'd1);
  endtask

  initial begin
    logic [9:0]  model_sh [3];
    bit          touched  [3];
    logic [2:0]  model_err;
    int          run;
    int          ch;
    int          last_idx [3];

    rst_i      = 1'b1;
    wr_i       = 1'b0;
    wr_ch_i    = '0;
    wr_data_i  = '0;
    wr_pd_i    = '0;
    refresh_i  = 1'b0;
    err_clr_i  = 1'b0;
    force_busy = 1'b0;
    nack_mode  = 0;
    fixed_lat  = 0;
    chk_hold   = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_go",     32'(bus.i2c_go_o),  32'd0);
    check("rst_adr",    32'(bus.i2c_adr_o), 32'd0);
    check("rst_dat",    32'(bus.i2c_dat_o), 32'd0);
    check("rst_busy",   32'(busy_o),        32'd0);
    check("rst_err",    32'(err_o),         32'd0);
    check("rst_shadow", 32'(shadow_o),      32'd0);
    rst_i = 1'b0;
    @(negedge clk);

    // Single write to channel 1
    write(2'd1, 2'b00, 8'hA5);
    wait_idle("t1");
    check("t1_count", 32'(adr_q.size()), 32'd1);
    if (adr_q.size() >= 1) begin
      check("t1_adr", 32'(adr_q[0]), 32'h0D);
      check("t1_dat", 32'(dat_q[0]), 32'(word_of(2'b00, 8'hA5)));
    end
    check("t1_busy",   32'(busy_o),          32'd0);
    check("t1_shadow", 32'(shadow_o[19:10]), 32'h0A5);

    // Three channels in quick succession, then refresh: order 0,1,2 twice
    do_reset();
    write(2'd0, 2'b01, 8'h11);
    write(2'd1, 2'b10, 8'h22);
    write(2'd2, 2'b00, 8'h33);
    wait_idle("t2a");
    pulse_refresh();
    wait_idle("t2b");
    check("t2_count", 32'(adr_q.size()), 32'd6);
    if (adr_q.size() == 6) begin
      for (int i = 0; i < 6; i++) check($sformatf("t2_adr%0d", i), 32'(adr_q[i]), 32'(exp_addr[i % 3]));
      check("t2_dat0", 32'(dat_q[3]), 32'(word_of(2'b01, 8'h11)));
      check("t2_dat1", 32'(dat_q[4]), 32'(word_of(2'b10, 8'h22)));
      check("t2_dat2", 32'(dat_q[5]), 32'(word_of(2'b00, 8'h33)));
    end

    // Persistent NACK: three attempts then sticky error, then clear
    do_reset();
    nack_mode = 1;
    write(2'd2, 2'b11, 8'h3C);
    wait_idle("t3");
    check("t3_count", 32'(adr_q.size()), 32'd3);
    foreach (dat_q[i]) begin
      check($sformatf("t3_adr%0d", i), 32'(adr_q[i]), 32'h0E);
      check($sformatf("t3_dat%0d", i), 32'(dat_q[i]), 32'h33C0);
    end
    check("t3_err", 32'(err_o), 32'b100);
    @(negedge clk);
    err_clr_i = 1'b1;
    @(negedge clk);
    err_clr_i = 1'b0;
    check("t3_err_clr", 32'(err_o), 32'd0);
    nack_mode = 0;

    // Rewrite while in flight: old word completes, new word follows
    do_reset();
    fixed_lat = 5;
    write(2'd0, 2'b00, 8'h10);
    wait_gos(1, "t4");
    write(2'd0, 2'b00, 8'h20);
    wait_idle("t4");
    check("t4_count", 32'(adr_q.size()), 32'd2);
    if (dat_q.size() == 2) begin
      check("t4_dat_first",  32'(dat_q[0]), 32'h0100);
      check("t4_dat_second", 32'(dat_q[1]), 32'h0200);
    end
    fixed_lat = 0;

    // Master held busy: no go until it drops, then go on the next cycle
    do_reset();
    @(negedge clk);
    force_busy = 1'b1;
    write(2'd1, 2'b00, 8'h5A);
    repeat (20) @(negedge clk);
    check("t5_no_go", 32'(adr_q.size()), 32'd0);
    force_busy = 1'b0;
    check("t5_go_low", 32'(bus.i2c_go_o), 32'd0);
    @(negedge clk);
    check("t5_go_high", 32'(bus.i2c_go_o), 32'd1);
    wait_idle("t5");
    check("t5_count", 32'(adr_q.size()), 32'd1);

    // Asynchronous reset during WAIT with another channel pending
    do_reset();
    fixed_lat = 12;
    write(2'd0, 2'b00, 8'h77);
    wait_gos(1, "t6");
    write(2'd1, 2'b00, 8'h88);
    #2;
    chk_hold = 1'b0;
    rst_i    = 1'b1;
    #1;
    check("t6_go",     32'(bus.i2c_go_o),  32'd0);
    check("t6_adr",    32'(bus.i2c_adr_o), 32'd0);
    check("t6_dat",    32'(bus.i2c_dat_o), 32'd0);
    check("t6_busy",   32'(busy_o),        32'd0);
    check("t6_shadow", 32'(shadow_o),      32'd0);
    @(negedge clk);
    rst_i = 1'b0;
    repeat (30) @(negedge clk);
    check("t6_no_more_go", 32'(adr_q.size()), 32'd1);
    check("t6_busy_after", 32'(busy_o),       32'd0);
    fixed_lat = 0;
    chk_hold  = 1'b1;

    // Randomized traffic against a transaction-level model
    do_reset();
    nack_mode = 2;
    for (int k = 0; k < 3; k++) begin
      model_sh[k] = '0;
      touched[k]  = 1'b0;
    end
    for (int it = 0; it < 150; it++) begin
      @(negedge clk);
      wr_i      = ($urandom_range(0, 1) == 1);
      wr_ch_i   = 2'($urandom_range(0, 3));
      wr_pd_i   = 2'($urandom_range(0, 3));
      wr_data_i = 8'($urandom_range(0, 255));
      refresh_i = ($urandom_range(0, 19) == 0);
      if (wr_i && wr_ch_i < 2'd3) begin
        model_sh[wr_ch_i] = {wr_pd_i, wr_data_i};
        touched[wr_ch_i]  = 1'b1;
      end
      if (refresh_i) for (int k = 0; k < 3; k++) touched[k] = 1'b1;
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        wr_i      = 1'b0;
        refresh_i = 1'b0;
        repeat ($urandom_range(1, 8)) @(negedge clk);
      end
    end
    @(negedge clk);
    wr_i      = 1'b0;
    refresh_i = 1'b0;
    wait_idle("rnd");

    for (int k = 0; k < 3; k++)
      check($sformatf("rnd_shadow%0d", k), 32'(shadow_o[10*k +: 10]), 32'(model_sh[k]));

    check("rnd_nack_align", 32'(nack_q.size()), 32'(adr_q.size()));
    model_err = '0;
    run       = 0;
    for (int k = 0; k < 3; k++) last_idx[k] = -1;
    for (int i = 0; i < adr_q.size(); i++) begin
      ch = -1;
      for (int k = 0; k < 3; k++) if (adr_q[i] == exp_addr[k]) ch = k;
      check($sformatf("rnd_adr_valid%0d", i), 32'(ch >= 0), 32'd1);
      if (ch >= 0) begin
        last_idx[ch] = i;
        if (i < nack_q.size() && nack_q[i]) begin
          run++;
          if (run == 3) begin
            model_err[ch] = 1'b1;
            run = 0;
          end
        end else begin
          run = 0;
        end
      end
    end
    check("rnd_err", 32'(err_o), 32'(model_err));
    for (int k = 0; k < 3; k++) begin
      if (touched[k]) begin
        check($sformatf("rnd_sent%0d", k), 32'(last_idx[k] >= 0), 32'd1);
        if (last_idx[k] >= 0)
          check($sformatf("rnd_final_word%0d", k), 32'(dat_q[last_idx[k]]),
                32'(word_of(model_sh[k][9:8], model_sh[k][7:0])));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
